// File: rtl/mv_pkg.sv
// Shared types and constants for the move sequencer.
//   mv_state_t     : sequencer states
//   STEP_FAST/SLOW : forward-speed ramp steps (simulation / silicon)
//   *_DFLT         : default ceiling and heading tolerance
//   hdg_mag()      : magnitude of a wrapped 12-bit heading error
package mv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    RAMP_UP,
    RAMP_DN,
    DONE
  } mv_state_t;

  localparam logic [9:0]  STEP_FAST      = 10'h020;
  localparam logic [9:0]  STEP_SLOW      = 10'h004;
  localparam logic [9:0]  FRWRD_MAX_DFLT = 10'h300;
  localparam logic [11:0] ERR_TOL_DFLT   = 12'h02C;

  // -12'h800 has no positive counterpart; it maps to 12'h800, which is
  // always above any sensible tolerance, so it never reads as settled.
  function automatic logic [11:0] hdg_mag(input logic [11:0] e);
    return e[11] ? 12'(-e) : e;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Command and PID-side signal bundle of the move sequencer.
//   master : command processor / sensors / PID observer side
//   slave  : the sequencer itself
interface move_sequencer_if;
  logic        cmd_vld;
  logic [11:0] cmd_hdg;
  logic [3:0]  cmd_sqrs;
  logic        cmd_rdy;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        cntrIR;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic        mv_done;

  modport master (
    output cmd_vld, cmd_hdg, cmd_sqrs, heading, heading_rdy, cntrIR,
    input  cmd_rdy, moving, err_vld, error, frwrd, mv_done
  );

  modport slave (
    input  cmd_vld, cmd_hdg, cmd_sqrs, heading, heading_rdy, cntrIR,
    output cmd_rdy, moving, err_vld, error, frwrd, mv_done
  );
endinterface

// File: rtl/frwrd_ramp.sv
// Saturating 10-bit forward-speed counter.
//   clk, rst : clock, async active-high reset
//   clr      : force to zero (highest priority after reset)
//   inc      : add step, saturating at max
//   dec      : subtract 2*step, floored at zero
//   step,max : ramp step and ceiling
//   frwrd    : current speed; at_max / at_zero flags
module frwrd_ramp (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  input  logic [9:0] step,
  input  logic [9:0] max,
  output logic [9:0] frwrd,
  output logic       at_max,
  output logic       at_zero
);

  // 11-bit sums so neither direction can wrap before the clamp
  logic [10:0] up_sum;
  logic [10:0] dn_amt;

  assign up_sum  = {1'b0, frwrd} + {1'b0, step};
  assign dn_amt  = {step, 1'b0};
  assign at_max  = (frwrd >= max);
  assign at_zero = (frwrd == 10'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frwrd <= '0;
    end else if (clr) begin
      frwrd <= '0;
    end else if (inc) begin
      frwrd <= (up_sum >= {1'b0, max}) ? max : up_sum[9:0];
    end else if (dec) begin
      frwrd <= ({1'b0, frwrd} <= dn_amt) ? '0 : frwrd - dn_amt[9:0];
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Sequences the heading PID for a single move: turn to heading, ramp
// forward speed up, count line crossings, ramp down, report done.
//   clk, rst : clock, async active-high reset
//   bus      : command handshake, heading/line sensors, PID outputs
// Parameters: FAST_SIM picks the ramp step, FRWRD_MAX the speed ceiling,
// ERR_TOL the heading error below which a turn is settled.
module move_sequencer
  import mv_pkg::*;
#(
  parameter bit          FAST_SIM  = 1'b1,
  parameter logic [9:0]  FRWRD_MAX = FRWRD_MAX_DFLT,
  parameter logic [11:0] ERR_TOL   = ERR_TOL_DFLT
) (
  input logic              clk,
  input logic              rst,
  move_sequencer_if.slave  bus
);

  mv_state_t   state;
  logic [11:0] hdg_reg;
  logic [3:0]  sqr_reg;
  logic [4:0]  cnt;
  logic        ir_q;
  logic        moving_r;
  logic        err_vld_r;
  logic [11:0] error_r;
  logic        mv_done_r;
  logic        cmd_rdy_r;

  logic [9:0]  step;
  logic [11:0] err_now;
  logic        settled;
  logic        rise;
  logic [4:0]  cnt_nxt;
  logic        inc;
  logic        dec;
  logic        clr;
  logic [9:0]  frwrd;
  logic        at_max;
  logic        at_zero;

  assign step    = FAST_SIM ? STEP_FAST : STEP_SLOW;
  // Wraps modulo 4096 on purpose: heading is circular.
  assign err_now = hdg_reg - bus.heading;
  assign settled = (hdg_mag(err_now) < ERR_TOL);
  // ir_q tracks the sensor in every state, so a line already under the
  // sensor when RAMP_UP starts is not mistaken for a fresh crossing.
  assign rise    = bus.cntrIR & ~ir_q;
  assign cnt_nxt = cnt + 5'd1;

  assign inc = (state == RAMP_UP) & bus.heading_rdy & ~at_max;
  assign dec = (state == RAMP_DN) & bus.heading_rdy & ~at_zero;
  assign clr = (state == IDLE);

  frwrd_ramp u_ramp (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .dec     (dec),
    .clr     (clr),
    .step    (step),
    .max     (FRWRD_MAX),
    .frwrd   (frwrd),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  assign bus.frwrd   = frwrd;
  assign bus.moving  = moving_r;
  assign bus.err_vld = err_vld_r;
  assign bus.error   = error_r;
  assign bus.mv_done = mv_done_r;
  assign bus.cmd_rdy = cmd_rdy_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hdg_reg   <= '0;
      sqr_reg   <= '0;
      cnt       <= '0;
      ir_q      <= 1'b0;
      moving_r  <= 1'b0;
      err_vld_r <= 1'b0;
      error_r   <= '0;
      mv_done_r <= 1'b0;
      cmd_rdy_r <= 1'b1;
    end else begin
      ir_q      <= bus.cntrIR;
      err_vld_r <= 1'b0;
      mv_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_vld) begin
            hdg_reg   <= bus.cmd_hdg;
            sqr_reg   <= bus.cmd_sqrs;
            cnt       <= '0;
            moving_r  <= 1'b1;
            cmd_rdy_r <= 1'b0;
            state     <= TURN;
          end
        end
        TURN: begin
          if (bus.heading_rdy) begin
            if (settled && (sqr_reg == 4'd0)) begin
              // DONE shows a quiet PID interface, so no error strobe here
              moving_r  <= 1'b0;
              mv_done_r <= 1'b1;
              error_r   <= '0;
              state     <= DONE;
            end else begin
              err_vld_r <= 1'b1;
              error_r   <= err_now;
              if (settled) state <= RAMP_UP;
            end
          end
        end
        RAMP_UP: begin
          if (bus.heading_rdy) begin
            err_vld_r <= 1'b1;
            error_r   <= err_now;
          end
          if (rise) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == {sqr_reg, 1'b0}) state <= RAMP_DN;
          end
        end
        RAMP_DN: begin
          if (at_zero) begin
            moving_r  <= 1'b0;
            mv_done_r <= 1'b1;
            error_r   <= '0;
            state     <= DONE;
          end else if (bus.heading_rdy) begin
            err_vld_r <= 1'b1;
            error_r   <= err_now;
          end
        end
        DONE: begin
          cmd_rdy_r <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          moving_r  <= 1'b0;
          error_r   <= '0;
          cmd_rdy_r <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

  localparam int STEP = 'h020;
  localparam int FMAX = 'h300;
  localparam int TOL  = 'h02C;

  localparam int PI = 0, PT = 1, PU = 2, PD = 3, PDN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  move_sequencer_if bus();

  move_sequencer #(.FAST_SIM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // reference model state
  int m_ph = PI, m_hdg = 0, m_sqr = 0, m_cnt = 0, m_fw = 0;
  bit m_ir = 1'b0;
  int e_mov = 0, e_ev = 0, e_err = 0, e_done = 0, e_rdy = 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_finish();
    m_ph   = PDN;
    e_mov  = 0;
    e_done = 1;
    e_err  = 0;
  endtask

  always @(posedge clk) begin
    int d, mag;
    bit rise;
    if (rst) begin
      m_ph = PI; m_hdg = 0; m_sqr = 0; m_cnt = 0; m_fw = 0; m_ir = 1'b0;
      e_mov = 0; e_ev = 0; e_err = 0; e_done = 0; e_rdy = 1;
    end else begin
      rise = bus.cntrIR && !m_ir;
      m_ir = bus.cntrIR;
      d    = (m_hdg - int'(bus.heading)) & 'hFFF;
      mag  = (d >= 2048) ? 4096 - d : d;
      e_ev = 0;
      e_done = 0;
      case (m_ph)
        PI: begin
          m_fw = 0;
          if (bus.cmd_vld) begin
            m_hdg = int'(bus.cmd_hdg);
            m_sqr = int'(bus.cmd_sqrs);
            m_cnt = 0;
            m_ph  = PT;
            e_mov = 1;
            e_rdy = 0;
          end
        end
        PT: if (bus.heading_rdy) begin
          if (mag < TOL && m_sqr == 0) m_finish();
          else begin
            e_ev = 1; e_err = d;
            if (mag < TOL) m_ph = PU;
          end
        end
        PU: begin
          if (bus.heading_rdy) begin
            m_fw = (m_fw + STEP > FMAX) ? FMAX : m_fw + STEP;
            e_ev = 1; e_err = d;
          end
          if (rise) begin
            m_cnt++;
            if (m_cnt == 2 * m_sqr) m_ph = PD;
          end
        end
        PD: begin
          if (m_fw == 0) m_finish();
          else if (bus.heading_rdy) begin
            m_fw = (m_fw - 2 * STEP < 0) ? 0 : m_fw - 2 * STEP;
            e_ev = 1; e_err = d;
          end
        end
        default: begin
          m_ph  = PI;
          e_rdy = 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("moving",  int'(bus.moving),  e_mov);
      chk("err_vld", int'(bus.err_vld), e_ev);
      chk("mv_done", int'(bus.mv_done), e_done);
      chk("cmd_rdy", int'(bus.cmd_rdy), e_rdy);
      chk("frwrd",   int'(bus.frwrd),   m_fw);
      if (e_ev == 1 || m_ph == PI || m_ph == PDN)
        chk("error", int'(bus.error), e_err);
    end
  end

  task automatic tick(input logic vld, input logic [11:0] ch, input logic [3:0] cs,
                      input logic [11:0] hd, input logic hr, input logic ir);
    @(negedge clk);
    bus.cmd_vld     = vld;
    bus.cmd_hdg     = ch;
    bus.cmd_sqrs    = cs;
    bus.heading     = hd;
    bus.heading_rdy = hr;
    bus.cntrIR      = ir;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.cmd_vld = 1'b0; bus.cmd_hdg = '0; bus.cmd_sqrs = '0;
    bus.heading = '0; bus.heading_rdy = 1'b0; bus.cntrIR = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", int'(bus.cmd_rdy), 1);
    chk("rst_frwrd",   int'(bus.frwrd),   0);
    chk("rst_moving",  int'(bus.moving),  0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // pure turn
    tick(1'b1, 12'h3FF, 4'd0, 12'h000, 1'b0, 1'b0);
    settle();
    chk("turn_moving", int'(bus.moving), 1);
    tick(1'b0, 12'h000, 4'd0, 12'h000, 1'b1, 1'b0);
    settle();
    chk("turn_err_a", int'(bus.error), 'h3FF);
    tick(1'b0, 12'h000, 4'd0, 12'h000, 1'b1, 1'b1);
    settle();
    chk("turn_err_b", int'(bus.error), 'h3FF);
    tick(1'b0, 12'h000, 4'd0, 12'h3F0, 1'b1, 1'b0);
    settle();
    chk("turn_done", int'(bus.mv_done), 1);
    chk("turn_frwrd", int'(bus.frwrd), 0);
    tick(1'b0, 12'h000, 4'd0, 12'h3F0, 1'b0, 1'b0);
    settle();
    chk("turn_done_once", int'(bus.mv_done), 0);
    chk("turn_rdy_back", int'(bus.cmd_rdy), 1);

    // one-square move, with line edges during TURN that must not count
    tick(1'b1, 12'h100, 4'd1, 12'h100, 1'b0, 1'b0);
    tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b0, 1'b1);
    tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b0, 1'b0);
    tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b0, 1'b1);
    tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b1, 1'b0);
    tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b1, 1'b0);
    settle();
    chk("ramp_first", int'(bus.frwrd), 'h020);
    for (int i = 0; i < 30; i++) tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b1, 1'b0);
    settle();
    chk("ramp_sat", int'(bus.frwrd), 'h300);
    tick(1'b1, 12'h555, 4'd9, 12'h100, 1'b0, 1'b0);
    settle();
    chk("busy_rdy", int'(bus.cmd_rdy), 0);
    tick(1'b0, 12'h000, 4'd0, 12'h0F0, 1'b1, 1'b0);
    settle();
    chk("busy_hdg_kept", int'(bus.error), 'h010);
    for (int i = 0; i < 6; i++) tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b0, 1'b0);
    tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b0, 1'b1);
    tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b1, 1'b1);
    settle();
    chk("ramp_dn_first", int'(bus.frwrd), 'h2C0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b1, 1'b0);
      settle();
      if (bus.mv_done) begin
        seen = 1'b1;
        chk("dn_done_frwrd", int'(bus.frwrd), 0);
      end
    end
    chk("move_done_seen", int'(seen), 1);
    tick(1'b0, 12'h000, 4'd0, 12'h100, 1'b0, 1'b0);

    // heading wrap, then reset mid-ramp
    tick(1'b1, 12'h7F0, 4'd1, 12'h810, 1'b0, 1'b0);
    tick(1'b0, 12'h000, 4'd0, 12'h810, 1'b1, 1'b0);
    settle();
    chk("wrap_err", int'(bus.error), 'hFE0);
    chk("wrap_settled_vld", int'(bus.err_vld), 1);
    for (int i = 0; i < 8; i++) tick(1'b0, 12'h000, 4'd0, 12'h810, 1'b1, 1'b0);
    settle();
    chk("mid_frwrd", int'(bus.frwrd), 'h100);
    tick(1'b0, 12'h000, 4'd0, 12'h810, 1'b0, 1'b0);
    rst = 1'b1;
    settle();
    chk("mrst_frwrd",  int'(bus.frwrd), 0);
    chk("mrst_moving", int'(bus.moving), 0);
    chk("mrst_rdy",    int'(bus.cmd_rdy), 1);
    chk("mrst_ev",     int'(bus.err_vld), 0);
    chk("mrst_err",    int'(bus.error), 0);
    chk("mrst_done",   int'(bus.mv_done), 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized moves against the model
    for (int mv = 0; mv < 14; mv++) begin
      int hdg, sq, turn_hr, hd;
      bit hr, ir, done;
      hdg = int'($urandom_range(0, 4095));
      sq  = int'($urandom_range(0, 4));
      ir  = 1'b0;
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
        tick(1'b0, 12'h000, 4'd0, 12'h000, 1'b0, ir);
        settle();
        if (e_rdy == 1) seen = 1'b1;
      end
      chk("rand_idle_wait", int'(seen), 1);
      tick(1'b1, 12'(hdg), 4'(sq), 12'(hdg ^ 'h800), 1'b0, ir);
      turn_hr = 0;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
        hr = ($urandom_range(0, 2) == 0);
        if (m_ph == PT && turn_hr < 2) hd = hdg ^ 'h800;
        else hd = (hdg + int'($urandom_range(0, 80)) - 40) & 'hFFF;
        if (m_ph == PT && hr) turn_hr++;
        if ($urandom_range(0, 5) == 0) ir = ~ir;
        tick(($urandom_range(0, 9) == 0), 12'($urandom), 4'($urandom), 12'(hd), hr, ir);
        settle();
        if (e_done == 1) done = 1'b1;
      end
      chk("rand_move_done", int'(done), 1);
    end

    repeat (3) tick(1'b0, 12'h000, 4'd0, 12'h000, 1'b0, 1'b0);
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
